// File: rtl/harris_pkg.sv
// Shared widths, decision modes and defaults for the Harris corner pipeline.
package harris_pkg;

   localparam int unsigned K_SHIFT_DEF = 5;

   typedef enum logic [1:0] {
      MODE_ANY  = 2'd0,
      MODE_ALL  = 2'd1,
      MODE_SUM  = 2'd2,
      MODE_RSVD = 2'd3
   } harris_mode_e;

   // Product width of one gradient tap squared or crossed.
   function automatic int unsigned pw_f(input int unsigned gw);
      return 2 * gw;
   endfunction

   // Window-sum width: product width plus growth over WIN*WIN taps.
   function automatic int unsigned sw_f(input int unsigned gw, input int unsigned win);
      return pw_f(gw) + $clog2(win * win);
   endfunction

   // Response width: det/tr2 width plus growth of the channel sum.
   function automatic int unsigned rw_f(input int unsigned gw, input int unsigned win,
                                        input int unsigned num_ch);
      return 2 * sw_f(gw, win) + 2 + $clog2(num_ch);
   endfunction

endpackage

// File: rtl/harris_stream_detector_if.sv
// Input/output stream bundle of the Harris detector.
// Tap layout on s_ix/s_iy: channel c, tap t at bits [(c*WIN*WIN + t)*GW +: GW].
interface harris_stream_detector_if #(
   parameter int unsigned NUM_CH = 3,
   parameter int unsigned WIN    = 3,
   parameter int unsigned GW     = 9
);
   import harris_pkg::*;

   localparam int unsigned TW = NUM_CH * WIN * WIN * GW;
   localparam int unsigned RW = rw_f(GW, WIN, NUM_CH);

   logic                 s_valid;
   logic                 s_ready;
   logic                 s_sof;
   logic [TW-1:0]        s_ix;
   logic [TW-1:0]        s_iy;
   logic                 m_valid;
   logic                 m_ready;
   logic                 m_sof;
   logic                 m_corner;
   logic [15:0]          m_pixel;
   logic signed [RW-1:0] m_resp;

   modport slave (
      input  s_valid, s_sof, s_ix, s_iy, m_ready,
      output s_ready, m_valid, m_sof, m_corner, m_pixel, m_resp
   );

   modport master (
      output s_valid, s_sof, s_ix, s_iy, m_ready,
      input  s_ready, m_valid, m_sof, m_corner, m_pixel, m_resp
   );

endinterface

// File: rtl/harris_channel_resp.sv
// One colour channel of the Harris pipe: tap products, window sums, det and tr2.
module harris_channel_resp
   import harris_pkg::*;
#(
   parameter int unsigned WIN = 3,
   parameter int unsigned GW  = 9
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               en_i,
   input  logic [WIN*WIN*GW-1:0]              ix_i,
   input  logic [WIN*WIN*GW-1:0]              iy_i,
   output logic signed [2*sw_f(GW, WIN)+1:0]  det_o,
   output logic signed [2*sw_f(GW, WIN)+1:0]  tr2_o
);

   localparam int unsigned NT = WIN * WIN;
   localparam int unsigned PW = pw_f(GW);
   localparam int unsigned SW = sw_f(GW, WIN);
   localparam int unsigned DW = 2 * SW + 2;

   logic signed [PW-1:0] ix_x [NT];
   logic signed [PW-1:0] iy_x [NT];
   logic signed [PW-1:0] xx_d [NT];
   logic signed [PW-1:0] yy_d [NT];
   logic signed [PW-1:0] xy_d [NT];
   logic signed [PW-1:0] xx_q [NT];
   logic signed [PW-1:0] yy_q [NT];
   logic signed [PW-1:0] xy_q [NT];
   logic signed [SW-1:0] a_d, b_d, c_d;
   logic signed [SW-1:0] a_q, b_q, c_q;
   logic signed [DW-1:0] tr_s, det_d, tr2_d;
   logic signed [DW-1:0] det_q, tr2_q;

   // S1: sign-extend each tap and form Ix^2, Iy^2, Ix*Iy
   always_comb begin
      for (int unsigned t = 0; t < NT; t++) begin
         ix_x[t] = PW'(signed'(ix_i[t*GW +: GW]));
         iy_x[t] = PW'(signed'(iy_i[t*GW +: GW]));
         xx_d[t] = ix_x[t] * ix_x[t];
         yy_d[t] = iy_x[t] * iy_x[t];
         xy_d[t] = ix_x[t] * iy_x[t];
      end
   end

   // S2: window sums A, B, C
   always_comb begin
      a_d = '0;
      b_d = '0;
      c_d = '0;
      for (int unsigned t = 0; t < NT; t++) begin
         a_d = a_d + SW'(xx_q[t]);
         b_d = b_d + SW'(yy_q[t]);
         c_d = c_d + SW'(xy_q[t]);
      end
   end

   // S3: det = A*B - C^2 and tr2 = (A+B)^2 at full precision
   always_comb begin
      tr_s  = DW'(a_q) + DW'(b_q);
      det_d = DW'(a_q) * DW'(b_q) - DW'(c_q) * DW'(c_q);
      tr2_d = tr_s * tr_s;
   end

   // Stage registers, all advancing on the shared enable
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         xx_q  <= '{default: '0};
         yy_q  <= '{default: '0};
         xy_q  <= '{default: '0};
         a_q   <= '0;
         b_q   <= '0;
         c_q   <= '0;
         det_q <= '0;
         tr2_q <= '0;
      end else if (en_i) begin
         xx_q  <= xx_d;
         yy_q  <= yy_d;
         xy_q  <= xy_d;
         a_q   <= a_d;
         b_q   <= b_d;
         c_q   <= c_d;
         det_q <= det_d;
         tr2_q <= tr2_d;
      end
   end

   assign det_o = det_q;
   assign tr2_o = tr2_q;

endmodule

// File: rtl/harris_stream_detector.sv
// Harris corner detector: NUM_CH channel pipes, S4 combine/compare, frame corner counter.
module harris_stream_detector
   import harris_pkg::*;
#(
   parameter int unsigned NUM_CH  = 3,
   parameter int unsigned WIN     = 3,
   parameter int unsigned GW      = 9,
   parameter int unsigned K_SHIFT = K_SHIFT_DEF,
   parameter int unsigned CNT_W   = 20
) (
   input  logic                                       clk,
   input  logic                                       rst_n,
   harris_stream_detector_if.slave                    bus,
   input  logic [1:0]                                 mode,
   input  logic signed [rw_f(GW, WIN, NUM_CH)-1:0]    threshold,
   output logic [CNT_W-1:0]                           frame_count,
   output logic                                       count_valid
);

   localparam int unsigned NT = WIN * WIN;
   localparam int unsigned CW = NT * GW;
   localparam int unsigned DW = 2 * sw_f(GW, WIN) + 2;
   localparam int unsigned RW = rw_f(GW, WIN, NUM_CH);

   logic                 en;
   logic [2:0]           v_q, sof_q;
   logic signed [DW-1:0] det_s [NUM_CH];
   logic signed [DW-1:0] tr2_s [NUM_CH];
   logic signed [RW-1:0] r_s   [NUM_CH];
   logic signed [RW-1:0] sum_r, max_r, resp_d;
   logic                 any_gt, all_gt, corner_d, corner_v;
   logic                 m_valid_q, m_sof_q, m_corner_q;
   logic [15:0]          m_pixel_q;
   logic signed [RW-1:0] m_resp_q;
   logic [CNT_W-1:0]     running_d, running_q, frame_count_d, frame_count_q;
   logic                 count_valid_d, count_valid_q;

   assign en          = !m_valid_q || bus.m_ready;
   assign bus.s_ready = en;

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      harris_channel_resp #(
         .WIN (WIN),
         .GW  (GW)
      ) u_resp (
         .clk   (clk),
         .rst_n (rst_n),
         .en_i  (en),
         .ix_i  (bus.s_ix[c*CW +: CW]),
         .iy_i  (bus.s_iy[c*CW +: CW]),
         .det_o (det_s[c]),
         .tr2_o (tr2_s[c])
      );
   end

   // Valid/sof shift alongside the S1..S3 data
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v_q   <= '0;
         sof_q <= '0;
      end else if (en) begin
         v_q   <= {v_q[1:0], bus.s_valid};
         sof_q <= {sof_q[1:0], bus.s_valid && bus.s_sof};
      end
   end

   // S4: per-channel response R_c = det - (tr2 >>> K_SHIFT)
   always_comb begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
         r_s[c] = RW'(det_s[c]) - RW'(tr2_s[c] >>> K_SHIFT);
      end
   end

   // S4: decision with live mode/threshold; reserved mode falls back to any-channel
   always_comb begin
      any_gt = 1'b0;
      all_gt = 1'b1;
      sum_r  = '0;
      max_r  = r_s[0];
      for (int unsigned c = 0; c < NUM_CH; c++) begin
         if (r_s[c] > threshold) any_gt = 1'b1;
         else                    all_gt = 1'b0;
         sum_r = sum_r + r_s[c];
         if (r_s[c] > max_r) max_r = r_s[c];
      end
      corner_d = any_gt;
      resp_d   = max_r;
      case (harris_mode_e'(mode))
         MODE_ALL: corner_d = all_gt;
         MODE_SUM: begin
            corner_d = sum_r > threshold;
            resp_d   = sum_r;
         end
         default: ;
      endcase
      corner_v = v_q[2] && corner_d;
   end

   // Output register stage; holds while downstream stalls
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_valid_q  <= 1'b0;
         m_sof_q    <= 1'b0;
         m_corner_q <= 1'b0;
         m_resp_q   <= '0;
         m_pixel_q  <= '0;
      end else if (en) begin
         m_valid_q  <= v_q[2];
         m_sof_q    <= sof_q[2];
         m_corner_q <= corner_v;
         m_resp_q   <= resp_d;
         m_pixel_q  <= corner_v ? 16'hFFFF : 16'h0000;
      end
   end

   // Frame counter next state: publish on sof handshake, else count corners (saturating)
   always_comb begin
      running_d     = running_q;
      frame_count_d = frame_count_q;
      count_valid_d = 1'b0;
      if (m_valid_q && bus.m_ready) begin
         if (m_sof_q) begin
            frame_count_d = running_q;
            count_valid_d = 1'b1;
            running_d     = CNT_W'(m_corner_q);
         end else if (m_corner_q && running_q != '1) begin
            running_d = running_q + CNT_W'(1);
         end
      end
   end

   // Frame counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         running_q     <= '0;
         frame_count_q <= '0;
         count_valid_q <= 1'b0;
      end else begin
         running_q     <= running_d;
         frame_count_q <= frame_count_d;
         count_valid_q <= count_valid_d;
      end
   end

   assign bus.m_valid  = m_valid_q;
   assign bus.m_sof    = m_sof_q;
   assign bus.m_corner = m_corner_q;
   assign bus.m_resp   = m_resp_q;
   assign bus.m_pixel  = m_pixel_q;
   assign frame_count  = frame_count_q;
   assign count_valid  = count_valid_q;

endmodule

// File: tb/tb_harris_stream_detector.sv
// Scoreboard bench for harris_stream_detector: directed plan beats plus random traffic.
module tb_harris_stream_detector;
   import harris_pkg::*;

   localparam int unsigned NUM_CH  = 3;
   localparam int unsigned WIN     = 3;
   localparam int unsigned GW      = 9;
   localparam int unsigned K_SHIFT = 5;
   localparam int unsigned CNT_W   = 20;
   localparam int unsigned NT      = WIN * WIN;
   localparam int unsigned RW      = rw_f(GW, WIN, NUM_CH);

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   logic [1:0]           mode;
   logic signed [RW-1:0] threshold;
   logic [CNT_W-1:0]     frame_count;
   logic                 count_valid;

   harris_stream_detector_if #(.NUM_CH(NUM_CH), .WIN(WIN), .GW(GW)) bus ();

   harris_stream_detector #(
      .NUM_CH  (NUM_CH),
      .WIN     (WIN),
      .GW      (GW),
      .K_SHIFT (K_SHIFT),
      .CNT_W   (CNT_W)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus         (bus),
      .mode        (mode),
      .threshold   (threshold),
      .frame_count (frame_count),
      .count_valid (count_valid)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit     corner;
      longint resp;
      bit     sof;
      int     acc_cyc;
      bit     chk_lat;
   } exp_t;

   exp_t   sb[$];
   exp_t   mon_e;
   int     checks = 0;
   int     errors = 0;
   int     cyc = 0;
   int     rdy_mode = 0;
   int     bix [NUM_CH][NT];
   int     biy [NUM_CH][NT];
   int     cur_mode = 0;
   longint cur_thr = 0;
   longint run_m = 0;
   longint fc_exp = 0;
   bit     cv_exp = 0;
   bit     prev_stall = 0;
   longint prev_resp = 0;
   bit     prev_corner = 0;
   bit     prev_sof = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference: Harris response from the window taps with plain integer arithmetic
   function automatic exp_t model();
      exp_t   e;
      longint a, b, c, r, sum, mx;
      bit     any, all;
      sum = 0; mx = 0; any = 0; all = 1;
      for (int ch = 0; ch < NUM_CH; ch++) begin
         a = 0; b = 0; c = 0;
         for (int t = 0; t < NT; t++) begin
            a += longint'(bix[ch][t]) * bix[ch][t];
            b += longint'(biy[ch][t]) * biy[ch][t];
            c += longint'(bix[ch][t]) * biy[ch][t];
         end
         r = (a * b - c * c) - (((a + b) * (a + b)) >>> K_SHIFT);
         if (ch == 0 || r > mx) mx = r;
         sum += r;
         if (r > cur_thr) any = 1; else all = 0;
      end
      case (cur_mode)
         1:       begin e.corner = all;           e.resp = mx;  end
         2:       begin e.corner = (sum > cur_thr); e.resp = sum; end
         default: begin e.corner = any;           e.resp = mx;  end
      endcase
      e.sof = 0; e.acc_cyc = 0; e.chk_lat = 0;
      return e;
   endfunction

   task automatic clear_beat();
      for (int ch = 0; ch < NUM_CH; ch++)
         for (int t = 0; t < NT; t++) begin
            bix[ch][t] = 0;
            biy[ch][t] = 0;
         end
   endtask

   task automatic corner_beat();
      clear_beat();
      bix[0][0] = 10;
      biy[0][4] = 10;
   endtask

   task automatic rand_beat();
      bit full;
      full = ($urandom_range(0, 1) == 1);
      for (int ch = 0; ch < NUM_CH; ch++)
         for (int t = 0; t < NT; t++) begin
            bix[ch][t] = full ? int'($urandom_range(0, 511)) - 256 : int'($urandom_range(0, 30)) - 15;
            biy[ch][t] = full ? int'($urandom_range(0, 511)) - 256 : int'($urandom_range(0, 30)) - 15;
         end
   endtask

   task automatic set_cfg(input int m, input longint thr);
      longint tv;
      cur_mode  = m;
      cur_thr   = thr;
      tv        = thr;
      mode      = 2'(m);
      threshold = tv[RW-1:0];
   endtask

   task automatic send(input bit sof);
      exp_t e;
      int   guard;
      guard = 0;
      for (int ch = 0; ch < NUM_CH; ch++)
         for (int t = 0; t < NT; t++) begin
            bus.s_ix[(ch*NT + t)*GW +: GW] = bix[ch][t][GW-1:0];
            bus.s_iy[(ch*NT + t)*GW +: GW] = biy[ch][t][GW-1:0];
         end
      bus.s_sof   = sof;
      bus.s_valid = 1'b1;
      forever begin
         @(negedge clk);
         if (bus.s_ready) break;
         guard++;
         if (guard > 200) begin
            checks++; errors++;
            $display("FAIL accept_timeout: s_ready stayed 0, expected 1 within 200 cycles");
            bus.s_valid = 1'b0;
            return;
         end
      end
      e         = model();
      e.sof     = sof;
      e.acc_cyc = cyc;
      e.chk_lat = (rdy_mode == 0);
      sb.push_back(e);
      @(posedge clk);
      #1;
      bus.s_valid = 1'b0;
      bus.s_sof   = 1'b0;
   endtask

   task automatic drain();
      int g;
      g = 0;
      while (sb.size() != 0 && g < 500) begin
         @(posedge clk);
         g++;
      end
      if (sb.size() != 0) begin
         checks++; errors++;
         $display("FAIL drain_timeout: %0d beats outstanding, expected 0", sb.size());
      end
      repeat (2) @(posedge clk);
      #1;
   endtask

   // Downstream ready: steady, 1-0-0-1 pattern, or random
   initial begin
      bus.m_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            1:       bus.m_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
            2:       bus.m_ready = ($urandom_range(0, 2) != 0);
            default: bus.m_ready = 1'b1;
         endcase
      end
   end

   // Monitor: pops the scoreboard on each output handshake and tracks frame totals
   always @(negedge clk) begin
      if (!rst_n) begin
         chk("rst_m_valid", bus.m_valid, 0);
         chk("rst_count_valid", count_valid, 0);
         sb.delete();
         run_m = 0; cv_exp = 0; prev_stall = 0;
      end else begin
         chk("s_ready", bus.s_ready, !bus.m_valid || bus.m_ready);
         chk("count_valid", count_valid, cv_exp);
         if (cv_exp) chk("frame_count", frame_count, fc_exp);
         cv_exp = 0;
         if (prev_stall) begin
            chk("hold_m_valid", bus.m_valid, 1);
            chk("hold_m_resp", bus.m_resp, prev_resp);
            chk("hold_m_corner", bus.m_corner, prev_corner);
            chk("hold_m_sof", bus.m_sof, prev_sof);
         end
         if (bus.m_valid && bus.m_ready) begin
            if (sb.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_beat: got output with resp %0d, expected none", bus.m_resp);
            end else begin
               mon_e = sb.pop_front();
               chk("m_corner", bus.m_corner, mon_e.corner);
               chk("m_resp", bus.m_resp, mon_e.resp);
               chk("m_pixel", bus.m_pixel, mon_e.corner ? 16'hFFFF : 16'h0000);
               chk("m_sof", bus.m_sof, mon_e.sof);
               if (mon_e.chk_lat) chk("latency", cyc - mon_e.acc_cyc, 4);
               if (mon_e.sof) begin
                  fc_exp = run_m;
                  cv_exp = 1;
                  run_m  = mon_e.corner ? 1 : 0;
               end else if (mon_e.corner && run_m < (longint'(1) << CNT_W) - 1) begin
                  run_m++;
               end
            end
         end
         prev_stall  = bus.m_valid && !bus.m_ready;
         prev_resp   = bus.m_resp;
         prev_corner = bus.m_corner;
         prev_sof    = bus.m_sof;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bit fa [8];
      bus.s_valid = 1'b0;
      bus.s_sof   = 1'b0;
      bus.s_ix    = '0;
      bus.s_iy    = '0;
      set_cfg(0, 0);
      repeat (3) @(posedge clk);
      #1;
      chk("reset_m_valid", bus.m_valid, 0);
      chk("reset_m_sof", bus.m_sof, 0);
      chk("reset_m_corner", bus.m_corner, 0);
      chk("reset_m_resp", bus.m_resp, 0);
      chk("reset_m_pixel", bus.m_pixel, 0);
      chk("reset_frame_count", frame_count, 0);
      chk("reset_count_valid", count_valid, 0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("reset_s_ready", bus.s_ready, 1);
      @(posedge clk);
      #1;

      // Single corner beat, then the mode/threshold variants of it
      corner_beat(); send(1); drain();
      set_cfg(1, 0);    corner_beat(); send(0); drain();
      set_cfg(2, 0);    corner_beat(); send(0); drain();
      set_cfg(0, 8750); corner_beat(); send(0); drain();
      set_cfg(0, 0);

      // Straight edge: strongly negative response
      clear_beat();
      for (int t = 0; t < NT; t++) bix[0][t] = 10;
      send(0); drain();

      // Backpressure stream
      rdy_mode = 1;
      for (int i = 0; i < 20; i++) begin
         rand_beat();
         send($urandom_range(0, 5) == 0);
      end
      drain();
      rdy_mode = 0;
      set_cfg(0, 0);

      // Frames: A = 5 corners in 8 beats, B starts with a corner, then back-to-back sofs
      fa = '{1, 1, 0, 1, 0, 1, 0, 1};
      for (int i = 0; i < 8; i++) begin
         if (fa[i]) corner_beat(); else clear_beat();
         send(i == 0);
      end
      corner_beat(); send(1);
      clear_beat();  send(0);
      corner_beat(); send(0);
      clear_beat();  send(1);
      clear_beat();  send(1);
      clear_beat();  send(1);
      drain();

      // Reset with beats in flight and a partial count
      corner_beat(); send(1); drain();
      for (int i = 0; i < 5; i++) begin
         corner_beat(); send(0);
      end
      rst_n = 1'b0;
      #1;
      chk("midrst_m_valid", bus.m_valid, 0);
      chk("midrst_count_valid", count_valid, 0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      corner_beat(); send(1);
      corner_beat(); send(0);
      clear_beat();  send(1);
      drain();

      // Random traffic, random ready, configuration changed between drained batches
      rdy_mode = 2;
      for (int bt = 0; bt < 6; bt++) begin
         case ($urandom_range(0, 2))
            0:       set_cfg(int'($urandom_range(0, 3)), 0);
            1:       set_cfg(int'($urandom_range(0, 3)), longint'($urandom_range(0, 200000)) - 100000);
            default: set_cfg(int'($urandom_range(0, 3)), longint'(int'($urandom)) * 16);
         endcase
         for (int i = 0; i < 30; i++) begin
            rand_beat();
            send($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 3) == 0) begin
               repeat ($urandom_range(1, 3)) @(posedge clk);
               #1;
            end
         end
         drain();
      end
      rdy_mode = 0;
      repeat (4) @(posedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
